cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control sequencer for the 8-bit processor datapath. Owns the program counter and instruction register. Steps each instruction through fetch, decode, execute, memory and write-back, and drives every datapath control line: register-file addresses and write enable, ALU op and source select, write-back mux select, and data-memory rd/wr. It also runs a ready/timeout handshake with data memory.

## Interface
- PC_W, 8, program-counter width; must equal the ins_mem address width
- RESET_PC, 8'h00, PC value loaded on reset
- MEM_TIMEOUT, 15, consecutive MEM cycles with mem_ready low before abort (range 1-255)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  level enable; high = keep issuing instructions
- instruction  in  8  ins_mem output for current pc_addr
- mem_ready  in  1  data memory done; sampled only in MEM
- pc_addr  out  PC_W  program counter to ins_mem
- rs1_addr, rs2_addr, wr_addr  out  2 each  register-file addresses
- immediate  out  2  immediate field to ALU / zero extension
- alu_op  out  2  ALU operation
- alu_src  out  1  0 = rs_data2, 1 = zero-extended immediate
- reg_wr_en  out  1  register-file write strobe
- regWriteSrc  out  2  00 = ALU result, 01 = data memory
- rd, wr  out  1 each  data-memory read / write enable
- state  out  3  current FSM state (debug)
- instr_count  out  8  retired-instruction counter
- mem_err  out  1  sticky memory-timeout flag

## Operation
- Instruction fields: op = ir[7:6], a = ir[5:4], b = ir[3:2], c = ir[1:0].
- op 00, ALU R-type: rd = a, rs1 = a, rs2 = b, alu_op = c, alu_src = 0.
- op 01, ADDI: rd = a, rs1 = b, imm = c, alu_op = 00, alu_src = 1.
- op 10, LOAD: rd = a, addr = rs1(b) + imm(c), alu_op = 00, alu_src = 1.
- op 11, STORE: data = rs2(a), addr = rs1(b) + imm(c), alu_op = 00, alu_src = 1.
- States and encodings:
  - IDLE (0): go to FETCH if run and !mem_err.
  - FETCH (1): ir <= instruction; go to DECODE.
  - DECODE (2): drive rs1_addr, rs2_addr, immediate; go to EXEC.
  - EXEC (3): also drive alu_op and alu_src. op 00/01 go to WB; op 10/11 go to MEM.
  - MEM (4): LOAD drives rd = 1; STORE drives wr = 1, with ALU controls held. Exit on mem_ready: LOAD goes to WB; STORE increments PC and instr_count, then goes to FETCH if run, else IDLE.
  - WB (5): reg_wr_en = 1 for exactly one cycle; wr_addr = a. regWriteSrc = 01 for LOAD (rd stays 1), 00 otherwise. Increment PC and instr_count; go to FETCH if run, else IDLE.
- Outputs are a Moore decode of state and ir. Outside the states listed above, all enables are 0 and addresses/fields are 0.
- Memory timeout: a counter increments on each MEM cycle with mem_ready low. When it reaches MEM_TIMEOUT, the FSM sets mem_err, goes to IDLE, and does not advance the PC. No register write occurs. The counter clears on leaving MEM.
- mem_err is sticky until reset. While it is set, IDLE ignores run.
- PC wraps from 2^PC_W-1 to 0 silently. instr_count wraps from 8'hFF to 0.
- run falling mid-instruction does not abort; the current instruction completes, then the FSM returns to IDLE.

## Timing
- Reset (asynchronous assert, synchronous release) sets: state = IDLE, pc = RESET_PC, ir = 0, instr_count = 0, mem_err = 0, timeout counter = 0. All enable outputs are 0.
- Reset mid-instruction aborts immediately; no write or strobe completes after assertion.
- Cycles per instruction with run held high:
  - R-type / ADDI: 4 (FETCH, DECODE, EXEC, WB).
  - LOAD: 5 + wait cycles.
  - STORE: 4 + wait cycles.
- mem_ready high in the first MEM cycle gives zero waits. mem_ready outside MEM is ignored.
- From IDLE, the first FETCH occurs in the cycle after run is sampled high.
- The PC updates at the end of the WB cycle (or the STORE MEM exit cycle), so the next FETCH sees the new pc_addr.

## Test plan
- Reset, then run = 0 for 10 cycles: state = 0, pc_addr = 00, all enables 0, instr_count = 0.
- ir = 8'b00_01_10_11 at pc 00, run = 1: states 1, 2, 3, 5. In WB: reg_wr_en = 1, wr_addr = 01, rs2_addr = 10, alu_op = 11, regWriteSrc = 00. pc_addr = 01 after 4 cycles.
- LOAD 8'b10_11_01_10 with mem_ready low for 2 MEM cycles: rd = 1 for 3 MEM cycles plus WB. WB has wr_addr = 11, regWriteSrc = 01, immediate = 10. Total 7 cycles.
- STORE 8'b11_00_01_01 with mem_ready = 1 immediately: wr = 1 for exactly 1 cycle, reg_wr_en never asserts, pc + 1, instr_count + 1.
- LOAD with MEM_TIMEOUT = 3 and mem_ready held low: mem_err = 1 after 3 MEM cycles, state = 0, pc unchanged, no reg_wr_en. run = 1 then stays in IDLE until reset.
- Boundary sweep:
  - RESET_PC = FF with an ADDI: pc_addr wraps to 00.
  - run dropped during DECODE: instruction completes, then state = 0.
  - reset asserted during MEM: wr drops asynchronously.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> datapath / memory bundle: fetch address, datapath control lines,
// data-memory handshake and debug status.
`timescale 1ns/1ps
interface cpu_sequencer_if #(
    parameter int PC_W = 8
);
    logic            run;
    logic [7:0]      instruction;
    logic            mem_ready;
    logic [PC_W-1:0] pc_addr;
    logic [1:0]      rs1_addr;
    logic [1:0]      rs2_addr;
    logic [1:0]      wr_addr;
    logic [1:0]      immediate;
    logic [1:0]      alu_op;
    logic            alu_src;
    logic            reg_wr_en;
    logic [1:0]      regWriteSrc;
    logic            rd;
    logic            wr;
    logic [2:0]      state;
    logic [7:0]      instr_count;
    logic            mem_err;

    modport master (
        input  run, instruction, mem_ready,
        output pc_addr, rs1_addr, rs2_addr, wr_addr, immediate, alu_op, alu_src,
               reg_wr_en, regWriteSrc, rd, wr, state, instr_count, mem_err
    );

    modport slave (
        output run, instruction, mem_ready,
        input  pc_addr, rs1_addr, rs2_addr, wr_addr, immediate, alu_op, alu_src,
               reg_wr_en, regWriteSrc, rd, wr, state, instr_count, mem_err
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns PC and IR, steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives all datapath and data-memory controls.
`timescale 1ns/1ps
module cpu_sequencer #(
    parameter int              PC_W        = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    cpu_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    localparam logic [7:0]      TMO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [PC_W-1:0] PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            retire;

    logic [1:0] op, fa, fb, fc;
    logic       is_load, is_store;

    assign op       = ir_q[7:6];
    assign fa       = ir_q[5:4];
    assign fb       = ir_q[3:2];
    assign fc       = ir_q[1:0];
    assign is_load  = (op == 2'b10);
    assign is_store = (op == 2'b11);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        retire  = 1'b0;

        case (state_q)
            S_IDLE:   if (bus.run && !err_q) state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = bus.instruction;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = op[1] ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.mem_ready) begin
                    tmo_d = 8'd0;
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = bus.run ? S_FETCH : S_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abort without retiring: PC and count stay on the failed access.
                    tmo_d   = 8'd0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = bus.run ? S_FETCH : S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase

        if (retire) begin
            pc_d  = pc_q + PC_ONE;
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 8'd0;
            cnt_q   <= 8'd0;
            tmo_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Moore decode: controls depend only on state_q and ir_q.
    logic       in_decode, in_alu;
    logic [1:0] rs1_addr, rs2_addr, wr_addr, immediate, alu_op, wsrc;
    logic       alu_src, reg_wr_en, rd_en, wr_en;

    assign in_decode = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                       (state_q == S_MEM)    || (state_q == S_WB);
    assign in_alu    = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

    always_comb begin
        rs1_addr  = 2'b00;
        rs2_addr  = 2'b00;
        immediate = 2'b00;
        alu_op    = 2'b00;
        alu_src   = 1'b0;
        wr_addr   = 2'b00;
        wsrc      = 2'b00;
        reg_wr_en = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;

        if (in_decode) begin
            case (op)
                2'b00: begin
                    rs1_addr = fa;
                    rs2_addr = fb;
                end
                2'b11: begin
                    rs1_addr  = fb;
                    rs2_addr  = fa;
                    immediate = fc;
                end
                default: begin
                    rs1_addr  = fb;
                    immediate = fc;
                end
            endcase
        end

        if (in_alu) begin
            alu_op  = (op == 2'b00) ? fc : 2'b00;
            alu_src = (op != 2'b00);
        end

        if (state_q == S_MEM) begin
            rd_en = is_load;
            wr_en = is_store;
        end

        if (state_q == S_WB) begin
            reg_wr_en = 1'b1;
            wr_addr   = fa;
            wsrc      = is_load ? 2'b01 : 2'b00;
            rd_en     = is_load;
        end
    end

    assign bus.pc_addr     = pc_q;
    assign bus.rs1_addr    = rs1_addr;
    assign bus.rs2_addr    = rs2_addr;
    assign bus.wr_addr     = wr_addr;
    assign bus.immediate   = immediate;
    assign bus.alu_op      = alu_op;
    assign bus.alu_src     = alu_src;
    assign bus.reg_wr_en   = reg_wr_en;
    assign bus.regWriteSrc = wsrc;
    assign bus.rd          = rd_en;
    assign bus.wr          = wr_en;
    assign bus.state       = state_q;
    assign bus.instr_count = cnt_q;
    assign bus.mem_err     = err_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus random instruction/wait-state
// streams, checked cycle by cycle against a per-instruction phase model.
`timescale 1ns/1ps
module tb_cpu_sequencer;
    localparam int         PC_W        = 8;
    localparam logic [7:0] RESET_PC    = 8'hFF;
    localparam int         MEM_TIMEOUT = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_sequencer_if #(.PC_W(PC_W)) bus ();

    cpu_sequencer #(
        .PC_W        (PC_W),
        .RESET_PC    (RESET_PC),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] imem [256];
    assign bus.instruction = imem[bus.pc_addr];

    logic [15:0] obs;
    assign obs = {bus.rs1_addr, bus.rs2_addr, bus.immediate, bus.alu_op, bus.alu_src,
                  bus.rd, bus.wr, bus.reg_wr_en, bus.wr_addr, bus.regWriteSrc};

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model: what the sequencer should have retired so far.
    logic [7:0] m_pc;
    logic [7:0] m_cnt;
    bit         m_err;
    bit         m_running;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control vector for one phase of an instruction, straight from the
    // field table (R-type, ADDI, LOAD, STORE).
    function automatic logic [15:0] exp_ctl(input logic [2:0] ph, input logic [7:0] ins);
        logic [1:0] op, a, b, c;
        logic [1:0] rs1, rs2, imm, aop, waddr, wsrc;
        logic       asrc, rdv, wrv, wen;
        op = ins[7:6]; a = ins[5:4]; b = ins[3:2]; c = ins[1:0];
        rs1 = 0; rs2 = 0; imm = 0; aop = 0; waddr = 0; wsrc = 0;
        asrc = 0; rdv = 0; wrv = 0; wen = 0;
        if (ph == ST_DECODE || ph == ST_EXEC || ph == ST_MEM || ph == ST_WB) begin
            unique case (op)
                2'd0: begin rs1 = a; rs2 = b; end
                2'd1: begin rs1 = b; imm = c; end
                2'd2: begin rs1 = b; imm = c; end
                2'd3: begin rs1 = b; rs2 = a; imm = c; end
            endcase
        end
        if (ph == ST_EXEC || ph == ST_MEM || ph == ST_WB) begin
            aop  = (op == 2'd0) ? c : 2'd0;
            asrc = (op != 2'd0);
        end
        if (ph == ST_MEM) begin
            rdv = (op == 2'd2);
            wrv = (op == 2'd3);
        end
        if (ph == ST_WB) begin
            wen   = 1'b1;
            waddr = a;
            wsrc  = (op == 2'd2) ? 2'd1 : 2'd0;
            rdv   = (op == 2'd2);
        end
        return {rs1, rs2, imm, aop, asrc, rdv, wrv, wen, waddr, wsrc};
    endfunction

    task automatic do_reset();
        reset         = 1'b0;
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("rst_state", bus.state, ST_IDLE);
        check("rst_pc", bus.pc_addr, RESET_PC);
        check("rst_cnt", bus.instr_count, 8'd0);
        check("rst_err", bus.mem_err, 1'b0);
        check("rst_ctl", obs, 16'd0);
        reset     = 1'b1;
        m_pc      = RESET_PC;
        m_cnt     = 8'd0;
        m_err     = 1'b0;
        m_running = 1'b0;
        @(negedge clk);
    endtask

    task automatic go_fetch();
        if (!m_running) begin
            bus.run = 1'b1;
            @(negedge clk);
            m_running = 1'b1;
        end
    endtask

    // Runs one instruction starting in its FETCH cycle. waits = MEM cycles with
    // mem_ready low before it rises; waits >= MEM_TIMEOUT means a timeout.
    task automatic do_instr(input logic [7:0] ins, input int waits, input bit drop);
        bit         is_mem, is_store, tmo, has_wb;
        int         n_mem, total;
        logic [2:0] ph;
        is_mem   = ins[7];
        is_store = (ins[7:6] == 2'b11);
        tmo      = is_mem && (waits >= MEM_TIMEOUT);
        n_mem    = !is_mem ? 0 : (tmo ? MEM_TIMEOUT : waits + 1);
        has_wb   = !tmo && !is_store;
        total    = 3 + n_mem + (has_wb ? 1 : 0);
        imem[m_pc] = ins;
        for (int i = 0; i < total; i++) begin
            if (i < 3)              ph = 3'(i + 1);
            else if (i < 3 + n_mem) ph = ST_MEM;
            else                    ph = ST_WB;
            check("state", bus.state, ph);
            check("ctl", obs, exp_ctl(ph, ins));
            if (ph == ST_MEM) bus.mem_ready = ((i - 3) == waits);
            else              bus.mem_ready = 1'($urandom);
            if (drop && ph == ST_DECODE) bus.run = 1'b0;
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        if (tmo) begin
            m_err = 1'b1;
        end else begin
            m_pc  = m_pc + 8'd1;
            m_cnt = m_cnt + 8'd1;
        end
        m_running = bus.run && !m_err;
        check("post_pc", bus.pc_addr, m_pc);
        check("post_cnt", bus.instr_count, m_cnt);
        check("post_err", bus.mem_err, m_err);
        check("post_state", bus.state, m_running ? ST_FETCH : ST_IDLE);
    endtask

    task automatic hold_err_idle();
        bus.run = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("err_idle_state", bus.state, ST_IDLE);
            check("err_sticky", bus.mem_err, 1'b1);
            check("err_pc", bus.pc_addr, m_pc);
            check("err_ctl", obs, 16'd0);
        end
    endtask

    initial begin
        logic [7:0] ins;
        int         waits;
        bit         drop;

        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        reset         = 1'b0;
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
        #2;
        do_reset();

        // Idle with run low: nothing moves.
        repeat (10) begin
            bus.mem_ready = 1'($urandom);
            @(negedge clk);
            check("idle_state", bus.state, ST_IDLE);
            check("idle_pc", bus.pc_addr, RESET_PC);
            check("idle_ctl", obs, 16'd0);
            check("idle_cnt", bus.instr_count, 8'd0);
        end
        bus.mem_ready = 1'b0;

        // ADDI at FF (PC wraps), R-type, LOAD with 2 waits, STORE with 0 waits.
        go_fetch();
        do_instr(8'b01_10_11_01, 0, 1'b0);
        do_instr(8'b00_01_10_11, 0, 1'b0);
        do_instr(8'b10_11_01_10, 2, 1'b0);
        do_instr(8'b11_00_01_01, 0, 1'b0);
        // run dropped during DECODE: completes, then IDLE.
        do_instr(8'b00_10_01_00, 0, 1'b1);
        @(negedge clk);
        check("drop_idle", bus.state, ST_IDLE);

        // LOAD timeout: sticky error, run ignored until reset.
        go_fetch();
        do_instr(8'b10_01_10_11, 5, 1'b0);
        hold_err_idle();
        do_reset();

        // Reset during a STORE's MEM phase drops wr asynchronously.
        go_fetch();
        imem[m_pc] = 8'b11_01_00_10;
        repeat (3) @(negedge clk);
        check("mem_wr_before_rst", bus.wr, 1'b1);
        reset = 1'b0;
        #1;
        check("rst_wr_async", bus.wr, 1'b0);
        check("rst_state_async", bus.state, ST_IDLE);
        check("rst_pc_async", bus.pc_addr, RESET_PC);
        @(negedge clk);
        do_reset();

        // Random instruction stream with random waits and run drops.
        for (int n = 0; n < 250; n++) begin
            if (m_err) begin
                hold_err_idle();
                do_reset();
            end
            go_fetch();
            ins   = 8'($urandom);
            waits = ($urandom_range(0, 15) == 0) ? int'($urandom_range(3, 4))
                                                 : int'($urandom_range(0, 2));
            drop  = ($urandom_range(0, 7) == 0);
            do_instr(ins, waits, drop);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
